// File: rtl/huff_decoder_if.sv
// Bus bundle for huff_decoder: code-map load, serial bit input and decoded symbol output.
interface huff_decoder_if #(
  parameter int SYM_W   = 3,
  parameter int MAX_LEN = 7
);
  logic               map_valid;
  logic [SYM_W-1:0]   map_sym;
  logic [MAX_LEN-1:0] map_code;
  logic [2:0]         map_len;
  logic               map_done;
  logic               bit_in;
  logic               bit_valid;
  logic [SYM_W-1:0]   sym_out;
  logic               sym_valid;
  logic               map_recv;
  logic               err;

  modport master (
    output map_valid, map_sym, map_code, map_len, map_done, bit_in, bit_valid,
    input  sym_out, sym_valid, map_recv, err
  );

  modport slave (
    input  map_valid, map_sym, map_code, map_len, map_done, bit_in, bit_valid,
    output sym_out, sym_valid, map_recv, err
  );
endinterface

// File: rtl/huff_decoder.sv
// Table-driven serial Huffman decoder: load a code map, then decode one bit per clock,
// emitting a one-cycle symbol pulse per matched code and a sticky error on overrun.
module huff_decoder #(
  parameter int SYM_W   = 3,
  parameter int NSYM    = 8,
  parameter int MAX_LEN = 7
) (
  input logic          clock,
  input logic          reset,
  huff_decoder_if.slave bus
);
  localparam int CW = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    DECODE = 2'd1,
    ERROR  = 2'd2
  } state_e;

  state_e             state_q;
  logic [MAX_LEN-1:0] code_q [NSYM];
  logic [2:0]         len_q  [NSYM];
  logic [NSYM-1:0]    vld_q;
  logic [MAX_LEN-1:0] acc_q;
  logic [CW-1:0]      cnt_q;
  logic [SYM_W-1:0]   sym_q;
  logic               sym_valid_q;
  logic               map_recv_q;
  logic               err_q;

  logic [MAX_LEN-1:0] acc_d;
  logic [MAX_LEN-1:0] mask_d;
  logic [CW-1:0]      cnt_d;
  logic               hit_d;
  logic [SYM_W-1:0]   hit_sym_d;

  // Candidate accumulator with the incoming bit, and the lowest-index table entry it matches.
  always_comb begin
    acc_d     = {acc_q[MAX_LEN-2:0], bus.bit_in};
    cnt_d     = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    mask_d    = '0;
    hit_d     = 1'b0;
    hit_sym_d = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(cnt_d)) begin
        mask_d[i] = 1'b1;
      end else begin
        mask_d[i] = 1'b0;
      end
    end
    // Scan downward so the lowest matching symbol index is the one left standing.
    for (int s = NSYM - 1; s >= 0; s--) begin
      if (vld_q[s] && (int'(len_q[s]) == int'(cnt_d)) &&
          (((code_q[s] ^ acc_d) & mask_d) == '0)) begin
        hit_d     = 1'b1;
        hit_sym_d = SYM_W'(s);
      end else begin
        hit_d     = hit_d;
        hit_sym_d = hit_sym_d;
      end
    end
  end

  // Control FSM, code table and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= LOAD;
      vld_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
      map_recv_q  <= 1'b0;
      err_q       <= 1'b0;
      for (int s = 0; s < NSYM; s++) begin
        code_q[s] <= '0;
        len_q[s]  <= 3'd0;
      end
    end else begin
      sym_valid_q <= 1'b0;
      case (state_q)
        LOAD: begin
          if (bus.map_valid) begin
            code_q[bus.map_sym] <= bus.map_code;
            len_q[bus.map_sym]  <= bus.map_len;
            vld_q[bus.map_sym]  <= (bus.map_len != 3'd0);
          end
          if (bus.map_done) begin
            state_q    <= DECODE;
            map_recv_q <= 1'b1;
          end
        end
        DECODE: begin
          if (bus.bit_valid) begin
            if (hit_d) begin
              sym_q       <= hit_sym_d;
              sym_valid_q <= 1'b1;
              acc_q       <= '0;
              cnt_q       <= '0;
            end else if (int'(cnt_d) == MAX_LEN) begin
              state_q <= ERROR;
              err_q   <= 1'b1;
              acc_q   <= '0;
              cnt_q   <= '0;
            end else begin
              acc_q <= acc_d;
              cnt_q <= cnt_d;
            end
          end
        end
        ERROR: begin
          err_q <= 1'b1;
        end
        default: begin
          state_q <= LOAD;
        end
      endcase
    end
  end

  assign bus.sym_out   = sym_q;
  assign bus.sym_valid = sym_valid_q;
  assign bus.map_recv  = map_recv_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_huff_decoder.sv
// Self-checking bench for huff_decoder: directed scenarios plus randomized maps and bit
// streams, all checked against an integer-arithmetic reference model.
module tb_huff_decoder;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  huff_decoder_if #(.SYM_W(3), .MAX_LEN(7)) bus ();
  huff_decoder #(.SYM_W(3), .NSYM(8), .MAX_LEN(7)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: 0=load, 1=decode, 2=error; codes kept as plain integers.
  int m_state;
  int m_code [8];
  int m_len  [8];
  bit m_val  [8];
  int m_acc, m_n;
  int e_sym;
  bit e_sv, e_recv, e_err;

  function automatic void model_reset();
    m_state = 0; m_acc = 0; m_n = 0;
    e_sym = 0; e_sv = 1'b0; e_recv = 1'b0; e_err = 1'b0;
    for (int s = 0; s < 8; s++) begin
      m_code[s] = 0; m_len[s] = 0; m_val[s] = 1'b0;
    end
  endfunction

  function automatic void model_edge(bit mv, int ms, int mc, int ml, bit md, bit bv, bit bi);
    int hit;
    e_sv = 1'b0;
    if (m_state == 0) begin
      if (mv) begin
        m_code[ms] = mc; m_len[ms] = ml; m_val[ms] = (ml != 0);
      end
      if (md) begin
        m_state = 1; e_recv = 1'b1;
      end
    end else if (m_state == 1 && bv) begin
      m_acc = m_acc * 2 + int'(bi);
      m_n   = m_n + 1;
      hit   = -1;
      for (int s = 0; s < 8; s++)
        if (hit < 0 && m_val[s] && m_len[s] == m_n && (m_code[s] % (1 << m_n)) == m_acc)
          hit = s;
      if (hit >= 0) begin
        e_sym = hit; e_sv = 1'b1; m_acc = 0; m_n = 0;
      end else if (m_n == 7) begin
        m_state = 2; e_err = 1'b1;
      end
    end
  endfunction

  function automatic logic [5:0] obs();
    return {bus.sym_valid, bus.sym_out, bus.map_recv, bus.err};
  endfunction

  function automatic logic [5:0] expv();
    return {e_sv, 3'(e_sym), e_recv, e_err};
  endfunction

  task automatic step(input bit mv, input int ms, input int mc, input int ml,
                      input bit md, input bit bv, input bit bi);
    bus.map_valid = mv;
    bus.map_sym   = 3'(ms);
    bus.map_code  = 7'(mc);
    bus.map_len   = 3'(ml);
    bus.map_done  = md;
    bus.bit_valid = bv;
    bus.bit_in    = bi;
    @(posedge clock);
    model_edge(mv, ms, mc, ml, md, bv, bi);
    #1;
  endtask

  task automatic load(input int s, input int c, input int l);
    step(1'b1, s, c, l, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic close_map();
    step(1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic send(input bit b);
    step(1'b0, 0, 0, 0, 1'b0, 1'b1, b);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.map_valid = 1'b0; bus.map_sym = 3'd0; bus.map_code = 7'd0; bus.map_len = 3'd0;
    bus.map_done = 1'b0; bus.bit_valid = 1'b0; bus.bit_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
  endtask

  task automatic load_basic_map();
    load(0, 0, 1); load(1, 2, 2); load(2, 6, 3); load(3, 7, 3);
    close_map();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (obs() !== 6'b000000) begin
      n_fail++; $display("FAIL reset_outputs: got %b want %b", obs(), 6'b000000);
    end
  endtask

  task automatic test_basic_decode();
    bit bits [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    int want_pos [4] = '{1, 3, 6, 9};
    int pos [$];
    int syms [$];
    do_reset();
    load_basic_map();
    n_cmp++;
    if (bus.map_recv !== 1'b1) begin
      n_fail++; $display("FAIL basic_map_recv: got %b want 1", bus.map_recv);
    end
    for (int i = 0; i < 9; i++) begin
      send(bits[i]);
      n_cmp++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL basic_bit%0d: got %b want %b", i + 1, obs(), expv());
      end
      if (bus.sym_valid === 1'b1) begin
        pos.push_back(i + 1); syms.push_back(int'(bus.sym_out));
      end
    end
    n_cmp++;
    if (pos.size() != 4) begin
      n_fail++; $display("FAIL basic_pulse_count: got %0d want 4", pos.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (pos[k] != want_pos[k] || syms[k] != k) begin
          n_fail++;
          $display("FAIL basic_pulse%0d: got bit %0d sym %0d want bit %0d sym %0d",
                   k, pos[k], syms[k], want_pos[k], k);
        end
      end
    end
  endtask

  task automatic test_idle_gaps();
    bit vld [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bit bts [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int pulses = 0;
    do_reset();
    load_basic_map();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 0, 0, 0, 1'b0, vld[i], bts[i]);
      n_cmp++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL gaps_cyc%0d: got %b want %b", i, obs(), expv());
      end
      if (bus.sym_valid === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 1 || bus.sym_valid !== 1'b1 || bus.sym_out !== 3'd2) begin
      n_fail++;
      $display("FAIL gaps_result: got pulses %0d last %b sym %0d want pulses 1 last 1 sym 2",
               pulses, bus.sym_valid, bus.sym_out);
    end
  endtask

  task automatic test_error();
    do_reset();
    load(0, 0, 1);
    close_map();
    for (int i = 0; i < 12; i++) begin
      send((i < 7) ? 1'b1 : 1'($urandom_range(0, 1)));
      n_cmp++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL error_bit%0d: got %b want %b", i + 1, obs(), expv());
      end
      n_cmp++;
      if (bus.err !== (i >= 6) || bus.sym_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL error_flag_bit%0d: got err %b sv %b want err %b sv 0",
                 i + 1, bus.err, bus.sym_valid, (i >= 6));
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    load_basic_map();
    send(1'b1);
    send(1'b1);
    reset = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if (obs() !== 6'b000000) begin
      n_fail++; $display("FAIL async_reset_immediate: got %b want %b", obs(), 6'b000000);
    end
    #2;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(1'b0);
      n_cmp++;
      if (obs() !== 6'b000000 || obs() !== expv()) begin
        n_fail++; $display("FAIL async_reset_ignore%0d: got %b want %b", i, obs(), 6'b000000);
      end
    end
  endtask

  task automatic test_overwrite();
    do_reset();
    load(5, 1, 1);
    step(1'b1, 5, 1, 0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (bus.map_recv !== 1'b1) begin
      n_fail++; $display("FAIL overwrite_map_recv: got %b want 1", bus.map_recv);
    end
    for (int i = 0; i < 7; i++) begin
      send(1'b1);
      n_cmp++;
      if (obs() !== expv() || bus.sym_valid !== 1'b0 || bus.err !== (i == 6)) begin
        n_fail++;
        $display("FAIL overwrite_bit%0d: got %b want %b", i + 1, obs(), expv());
      end
    end
  endtask

  task automatic test_priority();
    do_reset();
    load(1, 1, 2);
    load(4, 1, 2);
    close_map();
    send(1'b0);
    send(1'b1);
    n_cmp++;
    if (bus.sym_valid !== 1'b1 || bus.sym_out !== 3'd1 || obs() !== expv()) begin
      n_fail++;
      $display("FAIL priority: got sv %b sym %0d want sv 1 sym 1", bus.sym_valid, bus.sym_out);
    end
  endtask

  task automatic test_random();
    int ml;
    for (int t = 0; t < 8; t++) begin
      do_reset();
      for (int s = 0; s < 8; s++) begin
        ml = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7) : $urandom_range(1, 3);
        step(1'b1, $urandom_range(0, 7), $urandom_range(0, 127), ml,
             (s == 7) && ($urandom_range(0, 1) == 1), 1'b1, 1'($urandom_range(0, 1)));
      end
      if (e_recv == 1'b0) close_map();
      for (int c = 0; c < 60; c++) begin
        step(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 127),
             $urandom_range(0, 7), 1'($urandom_range(0, 1)),
             $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)));
        n_cmp++;
        if (obs() !== expv()) begin
          n_fail++; $display("FAIL random_t%0d_c%0d: got %b want %b", t, c, obs(), expv());
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_basic_decode();
    test_idle_gaps();
    test_error();
    test_async_reset();
    test_overwrite();
    test_priority();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/huff_decoder.md
HUFF_DECODER -- requirements
Module: huff_decoder

Interface
REQ-001 Parameter SYM_W, default 3: symbol width in bits.
REQ-002 Parameter NSYM, default 8: number of code-map entries (2**SYM_W).
REQ-003 Parameter MAX_LEN, default 7: maximum code length in bits; also the width of map_code.
REQ-004 Port clock, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port map_valid, input, 1: map_sym, map_code and map_len form a code-map entry this cycle.
REQ-007 Port map_sym, input, SYM_W: symbol index of the entry.
REQ-008 Port map_code, input, MAX_LEN: code value, right-aligned; bit [map_len-1] is the first transmitted bit.
REQ-009 Port map_len, input, 3: code length, 1..MAX_LEN; 0 invalidates the entry.
REQ-010 Port map_done, input, 1: code map complete; enter decode.
REQ-011 Port bit_in, input, 1: serial coded bit.
REQ-012 Port bit_valid, input, 1: bit_in is valid this cycle.
REQ-013 Port sym_out, output, SYM_W: decoded symbol.
REQ-014 Port sym_valid, output, 1: one-cycle pulse; sym_out is valid.
REQ-015 Port map_recv, output, 1: level; the code map is loaded and decoding is active.
REQ-016 Port err, output, 1: sticky; no code matched within MAX_LEN bits.

Function
REQ-017 The decoder SHALL implement three states: LOAD (after reset), DECODE and ERROR.
REQ-018 In LOAD, map_valid SHALL write {map_code, map_len} to table[map_sym] and set the entry's valid flag when map_len != 0, or clear it when map_len == 0.
REQ-019 A later write to the same map_sym SHALL overwrite the earlier one.
REQ-020 In LOAD, bit_valid SHALL be ignored.
REQ-021 map_done in LOAD SHALL move the state to DECODE and set map_recv at that edge.
- If map_valid is also high in that cycle, the entry SHALL be written first.
REQ-022 In DECODE and ERROR, map_valid and map_done SHALL be ignored; reloading the map requires reset.
REQ-023 In DECODE, each cycle with bit_valid=1 SHALL append bit_in as the LSB of a shift accumulator and increment the bit count n.
- The first bit received is the MSB of the code.
- Cycles with bit_valid=0 SHALL leave the accumulator and count unchanged.
REQ-024 A match SHALL occur when the accumulator including the new bit equals table[s].code[n-1:0] for a valid entry s with len == n.
REQ-025 On a match, at the same edge that samples the final bit:
- sym_out SHALL be set to s;
- sym_valid SHALL be set to 1 for exactly one cycle;
- the accumulator and count SHALL clear.
- Latency: sym_valid SHALL be high in the cycle after the last bit is presented.
REQ-026 If more than one entry matches, the lowest symbol index SHALL win.
REQ-027 If n reaches MAX_LEN with no match:
- err SHALL be set and the state SHALL go to ERROR;
- sym_valid SHALL stay 0.
REQ-028 In ERROR, err SHALL stay 1, sym_valid SHALL stay 0 and bit_valid SHALL be ignored until reset.
REQ-029 sym_out SHALL hold its last value between pulses.
REQ-030 Back-to-back codes with no idle cycles SHALL decode at a sustained rate of one bit per clock.

Reset
REQ-031 reset=1 SHALL immediately, without waiting for a clock edge:
- force the state to LOAD;
- clear all table valid flags, the accumulator and the count;
- drive sym_out=0, sym_valid=0, map_recv=0, err=0.
REQ-032 Reset asserted mid-code SHALL discard any partial code; no sym_valid SHALL follow.
REQ-033 After reset deasserts, the first active edge SHALL sample inputs under LOAD rules.

Verification
REQ-034 Map load and decode: load s0="0"/1, s1="10"/2, s2="110"/3, s3="111"/3, then map_done; send bits 0,1,0,1,1,0,1,1,1 -> sym_valid pulses with sym_out=0,1,2,3, each one cycle after bits 1, 3, 6 and 9; map_recv=1 from the map_done edge.
REQ-035 Idle gaps: same map, bits 1,(bit_valid=0 for 3 cycles),1,0 -> single pulse sym_out=2 one cycle after the final 0; no pulse during the gap.
REQ-036 Error: map only s0="0"/1; send seven 1s -> err=1 after the 7th bit; sym_valid never pulses; further bits are ignored.
REQ-037 Async reset: with the REQ-034 map, send 1,1 then pulse reset between edges -> all outputs 0 at once; map_recv=0; bit_valid is then ignored until a new map_done.
REQ-038 Overwrite and simultaneity: write s5="1"/1, then s5 with len=0 in the same cycle as map_done; send bit 1 -> state is DECODE; no match; the count continues.
REQ-039 Priority: s1="01"/2 and s4="01"/2; send 0,1 -> sym_out=1.
